// File: rtl/mii_rx_deframer_pkg.sv
// Shared constants and state encoding for the MII receive deframer.
package mii_rx_deframer_pkg;

    localparam int unsigned NIB_W               = 4;
    localparam int unsigned BYTE_W              = 8;
    localparam int unsigned DEF_PREAMBLE_MIN    = 10;
    localparam int unsigned DEF_MAX_FRAME_BYTES = 1522;
    localparam int unsigned DEF_LEN_W           = 11;

    localparam logic [NIB_W-1:0] PREAMBLE_NIBBLE = 4'h5;
    localparam logic [NIB_W-1:0] SFD_NIBBLE      = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_DATA_LO  = 3'd2,
        ST_DATA_HI  = 3'd3,
        ST_DROP     = 3'd4
    } rx_state_e;

endpackage

// File: rtl/mii_rx_nibble_pack.sv
// Nibble-to-byte packer with a one-byte hold buffer so the final byte can carry rx_eof.
module mii_rx_nibble_pack
    import mii_rx_deframer_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NIB_W-1:0]  nib,
    input  logic              lo_we,
    input  logic              hi_we,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              end_err,
    input  logic [LEN_W-1:0]  end_len,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_sof,
    output logic              rx_eof,
    output logic              rx_err,
    output logic [LEN_W-1:0]  rx_len
);

    logic [NIB_W-1:0]  lo_q, lo_d;
    logic [BYTE_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              sof_pend_q, sof_pend_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              sof_q, sof_d;
    logic              eof_q, eof_d;
    logic              err_q, err_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              emit;

    always_comb begin
        lo_d        = lo_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sof_pend_d  = sof_pend_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        err_d       = 1'b0;
        len_d       = '0;
        emit        = (hi_we || frame_end) && hold_full_q;

        if (lo_we) begin
            lo_d = nib;
        end
        if (hi_we) begin
            hold_d      = {nib, lo_q};
            hold_full_d = 1'b1;
        end
        // A completed byte or end of frame pushes out whatever was held.
        if (emit) begin
            valid_d    = 1'b1;
            data_d     = hold_q;
            sof_d      = sof_pend_q;
            sof_pend_d = 1'b0;
        end
        if (frame_end) begin
            eof_d       = 1'b1;
            err_d       = end_err;
            len_d       = end_len;
            hold_full_d = 1'b0;
        end
        if (frame_start) begin
            sof_pend_d  = 1'b1;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            sof_pend_q  <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= '0;
        end else begin
            lo_q        <= lo_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sof_pend_q  <= sof_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            err_q       <= err_d;
            len_q       <= len_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_sof   = sof_q;
    assign rx_eof   = eof_q;
    assign rx_err   = err_q;
    assign rx_len   = len_q;

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, counts bytes, flags errors, and drives the packer.
module mii_rx_deframer
    import mii_rx_deframer_pkg::*;
#(
    parameter int unsigned PREAMBLE_MIN    = DEF_PREAMBLE_MIN,
    parameter int unsigned MAX_FRAME_BYTES = DEF_MAX_FRAME_BYTES,
    parameter int unsigned LEN_W           = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic              rx_er,
    input  logic [NIB_W-1:0]  rxd,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_sof,
    output logic              rx_eof,
    output logic              rx_err,
    output logic [LEN_W-1:0]  rx_len
);

    localparam int unsigned PCNT_W = $clog2(PREAMBLE_MIN + 1);

    logic              dv_r_q;
    logic              er_r_q;
    logic [NIB_W-1:0]  rxd_r_q;

    rx_state_e         state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [LEN_W-1:0]  bcnt_q, bcnt_d;
    logic              err_q, err_d;
    logic              dv_prev_q, dv_prev_d;
    logic              armed_q, armed_d;

    logic              lo_we, hi_we, frame_start, frame_end, end_err;

    // Pin registers are deliberately not reset so a reset mid-frame cannot fake a low rx_dv.
    always_ff @(posedge clk) begin
        dv_r_q  <= rx_dv;
        er_r_q  <= rx_er;
        rxd_r_q <= rxd;
    end

    always_comb begin
        state_d     = state_q;
        pcnt_d      = pcnt_q;
        bcnt_d      = bcnt_q;
        err_d       = err_q;
        dv_prev_d   = dv_r_q;
        armed_d     = armed_q || !dv_r_q;
        lo_we       = 1'b0;
        hi_we       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        end_err     = err_q || (state_q == ST_DATA_HI) || (bcnt_q == '0)
                      || (bcnt_q > LEN_W'(MAX_FRAME_BYTES));

        case (state_q)
            ST_IDLE: begin
                // Only a genuine low-to-high edge of rx_dv starts a frame.
                if (dv_r_q && !dv_prev_q && armed_q) begin
                    if (rxd_r_q == PREAMBLE_NIBBLE) begin
                        state_d = ST_PREAMBLE;
                        pcnt_d  = PCNT_W'(1);
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!dv_r_q) begin
                    state_d = ST_IDLE;
                end else if (rxd_r_q == PREAMBLE_NIBBLE) begin
                    if (pcnt_q != PCNT_W'(PREAMBLE_MIN)) begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end else if ((rxd_r_q == SFD_NIBBLE) && (pcnt_q >= PCNT_W'(PREAMBLE_MIN))) begin
                    state_d     = ST_DATA_LO;
                    bcnt_d      = '0;
                    err_d       = 1'b0;
                    frame_start = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DATA_LO: begin
                if (!dv_r_q) begin
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    lo_we   = 1'b1;
                    err_d   = err_q || er_r_q;
                    state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (!dv_r_q) begin
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    hi_we   = 1'b1;
                    err_d   = err_q || er_r_q;
                    state_d = ST_DATA_LO;
                    if (bcnt_q != LEN_W'(MAX_FRAME_BYTES + 1)) begin
                        bcnt_d = bcnt_q + LEN_W'(1);
                    end
                end
            end
            ST_DROP: begin
                if (!dv_r_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pcnt_q    <= '0;
            bcnt_q    <= '0;
            err_q     <= 1'b0;
            dv_prev_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            bcnt_q    <= bcnt_d;
            err_q     <= err_d;
            dv_prev_q <= dv_prev_d;
            armed_q   <= armed_d;
        end
    end

    mii_rx_nibble_pack #(
        .LEN_W (LEN_W)
    ) u_pack (
        .clk         (clk),
        .rst         (rst),
        .nib         (rxd_r_q),
        .lo_we       (lo_we),
        .hi_we       (hi_we),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .end_err     (end_err),
        .end_len     (bcnt_q),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sof      (rx_sof),
        .rx_eof      (rx_eof),
        .rx_err      (rx_err),
        .rx_len      (rx_len)
    );

endmodule
